// File: rtl/seq_divider_32.sv
// 32-bit restoring shift-subtract divider, signed or unsigned, one quotient bit per cycle.
// Result registers change only on entry to DONE and hold through IDLE.
module seq_divider_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] work_q, work_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] quot_out_q, quot_out_d;
  logic [31:0] rem_out_q, rem_out_d;
  logic        dbz_q, dbz_d;
  logic [32:0] partial;
  logic        take;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (b == 32'd0) ? DONE : RUN;
      RUN:  if (count_q == 5'd31) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // work_q holds the dividend and collects quotient bits in its low end as it shifts
  always_comb begin
    count_d    = count_q;
    work_d     = work_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    partial    = {rem_q, work_q[31]};
    take       = (partial >= {1'b0, divisor_q});
    case (state_q)
      IDLE: begin
        if (start && (b != 32'd0)) begin
          work_d     = (sign && a[31]) ? (~a + 32'd1) : a;
          divisor_d  = (sign && b[31]) ? (~b + 32'd1) : b;
          rem_d      = 32'd0;
          count_d    = 5'd0;
          neg_quot_d = sign && (a[31] ^ b[31]);
          neg_rem_d  = sign && a[31];
        end else if (start) begin
          quot_out_d = 32'hFFFF_FFFF;
          rem_out_d  = a;
          dbz_d      = 1'b1;
        end
      end
      RUN: begin
        // partial < 2*divisor, so the difference always fits back in 32 bits
        rem_d   = take ? (partial[31:0] - divisor_q) : partial[31:0];
        work_d  = {work_q[30:0], take};
        count_d = count_q + 5'd1;
      end
      FIX: begin
        quot_out_d = neg_quot_q ? (~work_q + 32'd1) : work_q;
        rem_out_d  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        dbz_d      = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 5'd0;
      work_q     <= 32'd0;
      rem_q      <= 32'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_out_q <= 32'd0;
      rem_out_q  <= 32'd0;
      dbz_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: stimulus pushes expected results, a forked
// monitor pops and checks them whenever done is seen.
module tb_seq_divider_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          doneEdge;
  } expect_t;

  expect_t sbQueue[$];
  string   sbNames[$];
  int      compared;
  int      mismatched;
  int      cycleCount;
  int      doneSeen;

  seq_divider_32 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sign(sign),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request; the caller makes sure we are away from a rising edge
  task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn, input logic signIn,
                               input logic [31:0] expQ, input logic [31:0] expR, input logic expDbz,
                               input logic accept, input string name);
    expect_t e;
    a     = aIn;
    b     = bIn;
    sign  = signIn;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) begin
      e.q        = expQ;
      e.r        = expR;
      e.dbz      = expDbz;
      e.doneEdge = cycleCount + ((bIn == 32'd0) ? 1 : 34);
      sbQueue.push_back(e);
      sbNames.push_back(name);
    end
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sbQueue.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: pending=%0d, expected 0 within 200 cycles", name, sbQueue.size());
    end
  endtask

  initial begin
    int doneBefore;
    compared   = 0;
    mismatched = 0;
    cycleCount = 0;
    doneSeen   = 0;
    rst   = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && done) begin
          doneSeen++;
          if (sbQueue.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected done: q=0x%08h r=0x%08h, expected no done", quotient, remainder);
          end else begin
            expect_t e;
            string   n;
            e = sbQueue.pop_front();
            n = sbNames.pop_front();
            checkOutput({n, " quotient"}, quotient, e.q);
            checkOutput({n, " remainder"}, remainder, e.r);
            checkOutput({n, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
            checkOutput({n, " done edge"}, cycleCount + 1, e.doneEdge);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    @(negedge clk);
    applyStimulus(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0, 1'b1, "u20/3");
    waitIdle("u20/3");

    // 100/7 with cycle-by-cycle busy/done/hold checks
    @(negedge clk);
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, "u100/7");
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      checkOutput($sformatf("busy at N+%0d", k), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("done at N+%0d", k), {31'd0, done}, (k == 34) ? 32'd1 : 32'd0);
      if (k < 34) checkOutput($sformatf("held quotient at N+%0d", k), quotient, 32'd6);
    end
    @(negedge clk);
    checkOutput("busy after 100/7", {31'd0, busy}, 32'd0);
    checkOutput("quotient held in idle", quotient, 32'd14);
    checkOutput("remainder held in idle", remainder, 32'd2);

    @(negedge clk);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1, "s-7/2");
    waitIdle("s-7/2");
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, "u/0");
    waitIdle("u/0");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, "s overflow");
    waitIdle("s overflow");
    applyStimulus(32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1, 1'b1, "s-8/0");
    waitIdle("s-8/0");
    applyStimulus(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b1, "umax/16");
    waitIdle("umax/16");
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1, "s7/-2");
    waitIdle("s7/-2");
    applyStimulus(32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 1'b0, 1'b1, "u5/max");
    waitIdle("u5/max");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1, "umax/max-1");
    waitIdle("umax/max-1");
    applyStimulus(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 1'b0, 1'b1, "smin/2");
    waitIdle("smin/2");
    applyStimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b1, "s-100/-7");
    waitIdle("s-100/-7");

    // A start during RUN must be dropped without disturbing the operation
    doneBefore = doneSeen;
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, "busy-start 100/7");
    repeat (4) @(negedge clk);
    applyStimulus(32'd50, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "ignored 50/5");
    waitIdle("busy-start 100/7");
    repeat (40) @(negedge clk);
    checkOutput("done count with busy start", doneSeen, doneBefore + 1);

    // Start coinciding with done is dropped, the next idle cycle is taken
    applyStimulus(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0, 1'b1, "u20/3 again");
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
    end
    doneBefore = doneSeen;
    applyStimulus(32'h11, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "ignored done-start");
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1, "u9/3 after done");
    waitIdle("u9/3 after done");
    checkOutput("done count with done-cycle start", doneSeen, doneBefore + 1);

    // Reset in the middle of RUN aborts the operation and clears results
    @(negedge clk);
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, "aborted 100/7");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sbQueue.delete();
    sbNames.delete();
    @(negedge clk);
    checkOutput("mid-run reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid-run reset done", {31'd0, done}, 32'd0);
    checkOutput("mid-run reset quotient", quotient, 32'd0);
    checkOutput("mid-run reset remainder", remainder, 32'd0);
    checkOutput("mid-run reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    doneBefore = doneSeen;
    repeat (40) @(negedge clk);
    checkOutput("no done after abort", doneSeen, doneBefore);
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1, "u9/3 after reset");
    waitIdle("u9/3 after reset");
    checkOutput("scoreboard drained", sbQueue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
